// File: rtl/tx_rx_pkg.sv
// Shared tx/rx link definitions: payload and codeword widths, Hamming(12,8) bit positions.
package tx_rx_pkg;

    localparam int DATA_W = 8;
    localparam int CODE_W = 12;

    // Codeword positions are 1-based; position pos lives in bit pos-1.
    localparam int P1_POS = 1;
    localparam int P2_POS = 2;
    localparam int P4_POS = 4;
    localparam int P8_POS = 8;
    localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12};

    typedef logic [CODE_W-1:0] codeword_t;

endpackage

// File: rtl/transmit_hamming_tx_if.sv
// Enable/codeword bundle between the transmit block and its controller/channel.
interface transmit_hamming_tx_if;
    import tx_rx_pkg::*;

    logic      ctr_en;
    logic      conv_en_n;
    codeword_t reg_out;

    modport master (output ctr_en, output conv_en_n, input reg_out);
    modport slave  (input ctr_en, input conv_en_n, output reg_out);

endinterface

// File: rtl/transmit_hamming_tx_enc.sv
// hamming12_8_enc: combinational Hamming(12,8) encoder with even parity.
module hamming12_8_enc
    import tx_rx_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    output codeword_t         code_o
);

    always_comb begin
        code_o = '0;
        for (int i = 0; i < DATA_W; i++) begin
            code_o[DATA_POS[i]-1] = data_i[i];
        end
        code_o[P1_POS-1] = data_i[0] ^ data_i[1] ^ data_i[3] ^ data_i[4] ^ data_i[6];
        code_o[P2_POS-1] = data_i[0] ^ data_i[2] ^ data_i[3] ^ data_i[5] ^ data_i[6];
        code_o[P4_POS-1] = data_i[1] ^ data_i[2] ^ data_i[3] ^ data_i[7];
        code_o[P8_POS-1] = data_i[4] ^ data_i[5] ^ data_i[6] ^ data_i[7];
    end

endmodule

// File: rtl/transmit_hamming_tx.sv
// Transmit half of the tx/rx link: free-running payload counter feeding a registered Hamming encoder.
// Optional build macro TX_CTR_SATURATE_EN makes the counter stick at 255 instead of wrapping.
module transmit_hamming_tx
    import tx_rx_pkg::*;
#(
    parameter int CTR_STEP = 1
)
(
    input  logic                  clk,
    input  logic                  ctr_clr,
    transmit_hamming_tx_if.slave  tx
);

    localparam logic [DATA_W-1:0] STEP_V = DATA_W'(CTR_STEP);

    logic [DATA_W-1:0] ctr_q;
    logic [DATA_W-1:0] ctr_d;
    codeword_t         reg_out_q;
    codeword_t         reg_out_d;
    codeword_t         enc_cw;

    hamming12_8_enc u_enc (
        .data_i (ctr_q),
        .code_o (enc_cw)
    );

`ifdef TX_CTR_SATURATE_EN
    logic [DATA_W:0] ctr_sum;
    assign ctr_sum = {1'b0, ctr_q} + {1'b0, STEP_V};
`endif

    always_comb begin
        ctr_d = ctr_q;
        if (tx.ctr_en) begin
`ifdef TX_CTR_SATURATE_EN
            // Carry out means the step would pass 255: clamp there.
            ctr_d = ctr_sum[DATA_W] ? '1 : ctr_sum[DATA_W-1:0];
`else
            ctr_d = ctr_q + STEP_V;
`endif
        end
    end

    // Encoder sees the pre-edge count, so the codeword trails the counter by one edge.
    always_comb begin
        reg_out_d = reg_out_q;
        if (!tx.conv_en_n) begin
            reg_out_d = enc_cw;
        end
    end

    always_ff @(posedge clk) begin
        if (ctr_clr) begin
            ctr_q     <= '0;
            reg_out_q <= '0;
        end else begin
            ctr_q     <= ctr_d;
            reg_out_q <= reg_out_d;
        end
    end

    assign tx.reg_out = reg_out_q;

endmodule

// File: tb/tb_transmit_hamming_tx.sv
// Scoreboard bench for transmit_hamming_tx: per-edge expected codewords queued at drive time.
module tb_transmit_hamming_tx;
    import tx_rx_pkg::*;

    logic clk;
    logic ctr_clr;
    int   total = 0;
    int   bad   = 0;

    logic [11:0] exp_q [$];
    logic [7:0]  m_ctr;
    logic [11:0] m_reg;
    logic [7:0]  last_val;

    transmit_hamming_tx_if tx_if ();

    transmit_hamming_tx dut (
        .clk     (clk),
        .ctr_clr (ctr_clr),
        .tx      (tx_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference encoder built from the parity-coverage rule (parity at 2^k covers positions with bit k set).
    function automatic logic [11:0] ref_enc(input logic [7:0] d);
        logic [11:0] cw;
        int dpos [8] = '{3, 5, 6, 7, 9, 10, 11, 12};
        int ppos [4] = '{1, 2, 4, 8};
        cw = '0;
        for (int i = 0; i < 8; i++) cw[dpos[i]-1] = d[i];
        for (int k = 0; k < 4; k++) begin
            logic par;
            par = 1'b0;
            for (int pos = 1; pos <= 12; pos++)
                if (((pos & ppos[k]) != 0) && (pos != ppos[k])) par ^= cw[pos-1];
            cw[ppos[k]-1] = par;
        end
        return cw;
    endfunction

    function automatic logic [3:0] syndrome(input logic [11:0] cw);
        logic [3:0] s;
        s = '0;
        for (int pos = 1; pos <= 12; pos++)
            if (cw[pos-1]) s ^= 4'(pos);
        return s;
    endfunction

    function automatic logic [7:0] extract(input logic [11:0] cw);
        return {cw[11], cw[10], cw[9], cw[8], cw[6], cw[5], cw[4], cw[2]};
    endfunction

    function automatic logic [7:0] ctr_next(input logic [7:0] c);
`ifdef TX_CTR_SATURATE_EN
        return (c == 8'hFF) ? 8'hFF : c + 8'd1;
`else
        return c + 8'd1;
`endif
    endfunction

    task automatic step(input logic clr, input logic en, input logic cnv_n, input string tag);
        logic [11:0] e;
        @(negedge clk);
        ctr_clr         = clr;
        tx_if.ctr_en    = en;
        tx_if.conv_en_n = cnv_n;
        last_val = m_ctr;
        if (clr) begin
            m_reg = '0;
            m_ctr = '0;
        end else begin
            if (!cnv_n) m_reg = ref_enc(m_ctr);
            if (en)     m_ctr = ctr_next(m_ctr);
        end
        exp_q.push_back(m_reg);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk(tag, tx_if.reg_out, e);
    endtask

    initial begin
        m_ctr = '0;
        m_reg = '0;
        last_val = '0;
        ctr_clr = 1'b1;
        tx_if.ctr_en = 1'b0;
        tx_if.conv_en_n = 1'b1;

        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, "reset");
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, "idle_hold");

        // Count five with the converter off, then sample the count once.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, "count_stale");
        step(1'b0, 1'b0, 1'b0, "sample_ctr5");
        chk("ctr5_code", tx_if.reg_out, 12'h02D);

        // Freeze the counter while converting: same codeword repeats.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, "frozen_reenc");

        step(1'b1, 1'b0, 1'b1, "clear");
        step(1'b0, 1'b1, 1'b0, "enc00");
        chk("enc00_lit", tx_if.reg_out, 12'h000);
        step(1'b0, 1'b1, 1'b0, "enc01");
        chk("enc01_lit", tx_if.reg_out, 12'h007);
        step(1'b0, 1'b1, 1'b0, "enc02");
        chk("enc02_lit", tx_if.reg_out, 12'h019);
        step(1'b0, 1'b1, 1'b0, "run");

        // Clear wins over both enables mid-count.
        step(1'b1, 1'b1, 1'b0, "clr_wins");
        chk("clr_wins_lit", tx_if.reg_out, 12'h000);

        // Exhaustive sweep through wrap (or saturation) with structural checks.
        for (int i = 0; i < 258; i++) begin
            step(1'b0, 1'b1, 1'b0, "sweep");
            chk("sweep_data", {4'h0, extract(tx_if.reg_out)}, {4'h0, last_val});
            chk("sweep_synd", {8'h00, syndrome(tx_if.reg_out)}, 12'h000);
            if (last_val == 8'hFF && i == 255) chk("enc_ff_lit", tx_if.reg_out, 12'hF77);
        end
`ifdef TX_CTR_SATURATE_EN
        chk("after_ff", tx_if.reg_out, 12'hF77);
`else
        chk("after_ff", tx_if.reg_out, 12'h007);
`endif

        // Counter keeps moving while the converter is off; output stays stale.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, "stale_again");
        step(1'b1, 1'b0, 1'b1, "final_clr");
        step(1'b0, 1'b0, 1'b0, "after_clr_enc0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/transmit_hamming_tx.md
Name: transmit_hamming_tx

Overview:
- Transmit half of the tx/rx link.
- An 8-bit free-running data counter is the payload source.
- A converter stage encodes the current counter value into a 12-bit Hamming(12,8) codeword and registers it on reg_out, which feeds the channel/receiver.
- The counter is controlled by clear and enable inputs. The converter stage is gated by an active-low enable.

Parameters:
- DATA_W, 8, payload/counter width; only 8 is supported.
- CODE_W, 12, codeword width; only 12 is supported.
- CTR_STEP, 1, increment added per enabled cycle (1..255), modulo 2^DATA_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- ctr_clr  input  1  synchronous active-high reset; clears the counter and the output register.
- ctr_en  input  1  counter enable, active high.
- conv_en_n  input  1  converter enable, active low.
- reg_out  output  12  registered Hamming(12,8) codeword.

Interface: one clock (clk); reset is synchronous and active-high (ctr_clr). There is no asynchronous reset.

Behaviour:
- State consists of ctr_q[7:0] and reg_out[11:0]. Both are 0 after any edge with ctr_clr=1.
- Priority order: ctr_clr first, then the enables.
- Counter: on an edge with ctr_clr=0 and ctr_en=1, ctr_q <= ctr_q + CTR_STEP (mod 256, wraps 255->0 for step 1). With ctr_en=0, ctr_q holds.
- Converter: on an edge with ctr_clr=0 and conv_en_n=0, reg_out <= enc(ctr_q), using the pre-edge counter value. With conv_en_n=1, reg_out holds.
- Latency: reg_out shows the codeword of the counter value one edge after that value is present. When both enables are active, reg_out trails ctr_q by one count.
- Encoding uses codeword positions 1..12 mapped to reg_out[pos-1].
  - Parity bits sit at positions 1, 2, 4, 8.
  - Data bits d0..d7 sit at positions 3, 5, 6, 7, 9, 10, 11, 12.
  - Parity is even:
    - p1 = d0^d1^d3^d4^d6
    - p2 = d0^d2^d3^d5^d6
    - p4 = d1^d2^d3^d7
    - p8 = d4^d5^d6^d7
- Simultaneous ctr_clr with either enable: clear wins, and both registers become 0.
- Reset mid-operation: the next edge clears both registers. Operation resumes from count 0 on the first edge after ctr_clr drops.
- Enables are independent. Converting while the counter is frozen re-encodes the same value each cycle. Counting while the converter is disabled leaves reg_out stale.

Optional Feature:
- Macro: TX_CTR_SATURATE_EN.
- Defined: the counter saturates at 255 instead of wrapping. Once 255 is reached, ctr_q stays 255 while ctr_en=1, until ctr_clr is asserted.
- Undefined (default): modulo-256 wrap as specified above.

Decomposition:
- Shared package tx_rx_pkg holds:
  - DATA_W and CODE_W constants;
  - the parity position constants;
  - a codeword typedef logic [11:0].
- The receiver reuses the package.
- One natural sub-module is hamming12_8_enc: a purely combinational encoder mapping 8-bit data to a 12-bit codeword.
- The counter and the output register stay in the top module.

Test Plan:
- ctr_clr=1 for 4 cycles with both enables inactive -> ctr_q=0, reg_out=0x000; after release with ctr_en=0 and conv_en_n=1, both hold 0.
- ctr_en=1, conv_en_n=1 for 5 edges -> ctr_q=5, reg_out stays 0x000.
- From a cleared state, ctr_en=1, then conv_en_n=0 -> each edge reg_out=enc(prior count):
  - enc(0x01)=0x007
  - enc(0x02)=0x019
  - enc(0x00)=0x000
- Counter at 0xFF with conv_en_n=0 -> reg_out=0xF77 on the next edge. The following count wraps to 0x00, or holds 0xFF when TX_CTR_SATURATE_EN is defined.
- ctr_clr asserted together with ctr_en=1 and conv_en_n=0 mid-count -> next edge ctr_q=0, reg_out=0x000.
- Exhaustive check: all 256 counter values encoded; each reg_out has the data bits in the correct positions and all four parity checks even.
